// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I core types and constants
package rv32i_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_DROP = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - one-entry IF/ID slot with load, consume and flush
module if_id_reg #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic        consume,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   // flush beats load beats consume; id_pc is left alone unless loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= RESET_PC;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (valid && consume) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, imem handshake FSM and IF/ID slot
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   import rv32i_pkg::*;

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [XLEN-1:0] pc;
   logic            handshake;
   logic            load;

   assign handshake = imem_req && imem_gnt;
   assign load      = imem_rvalid && (state == FS_WAIT) && !redirect_valid;
   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FS_IDLE;
      else        state <= state_next;
   end

   // a redirect while a word is in flight parks in DROP until it returns
   always_comb begin
      state_next = state;
      case (state)
         FS_IDLE: state_next = FS_REQ;
         FS_REQ: begin
            if (handshake) state_next = redirect_valid ? FS_DROP : FS_WAIT;
         end
         FS_WAIT: begin
            if (imem_rvalid)         state_next = FS_REQ;
            else if (redirect_valid) state_next = FS_DROP;
         end
         FS_DROP: begin
            if (imem_rvalid) state_next = FS_REQ;
         end
         default: state_next = FS_IDLE;
      endcase
   end

   // only request once the slot is free or draining, so rvalid always finds room
   always_comb begin
      imem_req = (state == FS_REQ) && !(id_valid && stall);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= align_word(redirect_pc);
      else if (load)           pc <= pc + 32'd4;
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .flush      (redirect_valid),
      .consume    (!stall),
      .load_instr (imem_rdata),
      .load_pc    (pc),
      .valid      (id_valid),
      .instr      (id_instr),
      .pc         (id_pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        id_valid, id_valid2;
   logic [31:0] id_instr, id_instr2;
   logic [31:0] id_pc, id_pc2;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   typedef struct {
      logic        stall;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   int checks = 0;
   int failures = 0;

   entry_t      sb[$];
   entry_t      m_cur;
   logic        m_valid, expect_new;
   logic [31:0] m_pc;
   logic        pend, pend_sq, rv, pushed, hs, cur_rd, cur_st;
   logic [31:0] pend_addr;
   int          pend_left;
   int          rv_delay;
   vec_t        vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_valid = 1'b0; expect_new = 1'b0; m_pc = 32'h0;
      pend = 1'b0; pend_sq = 1'b0; pend_left = 0;
   endtask

   // set inputs for this cycle, let outputs settle, compare against the model
   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
      stall = st; redirect_valid = rd; redirect_pc = rpc;
      cur_st = st; cur_rd = rd;
      rv = pend && (pend_left == 0);
      imem_rvalid = rv;
      imem_rdata = rv ? (pend_addr ^ KEY) : 32'hDEAD_BEEF;
      imem_gnt = 1'b1;
      #1;
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      if (expect_new) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty actual=%0d required=1", sb.size());
         end else begin
            m_cur = sb.pop_front();
         end
         expect_new = 1'b0;
      end
      if (m_valid) begin
         chk("id_pc", id_pc, m_cur.pc);
         chk("id_instr", id_instr, m_cur.instr);
      end else begin
         chk("id_instr_nop", id_instr, NOP);
      end
      hs = imem_req && imem_gnt;
   endtask

   task automatic advance();
      pushed = rv && !cur_rd && !pend_sq;
      if (rv) pend = 1'b0;
      if (pushed) sb.push_back({pend_addr, pend_addr ^ KEY});
      if (cur_rd) begin
         m_pc = {redirect_pc[31:2], 2'b00};
         m_valid = 1'b0;
         if (pend) pend_sq = 1'b1;
      end else if (pushed) begin
         m_pc = m_pc + 32'd4;
         m_valid = 1'b1;
         expect_new = 1'b1;
      end else if (!cur_st) begin
         m_valid = 1'b0;
      end
      if (hs) begin
         pend = 1'b1; pend_addr = imem_addr; pend_left = rv_delay; pend_sq = cur_rd;
      end
      @(posedge clk);
      @(negedge clk);
      if (pend && pend_left > 0) pend_left--;
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      drive(st, rd, rpc);
      advance();
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
      vecs[4] = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h4};
      vecs[6] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h4};
      vecs[7] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h4};
      vecs[8] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
      vecs[9] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h4};

      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      rv_delay = 1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_instr", id_instr, NOP);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
      chk("rst_id_pc_wrap", id_pc2, 32'hFFFF_FFFC);
      @(negedge clk);
      rst_n = 1'b1;

      // streaming fetch, then a 3-cycle stall holding id_pc=4
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].stall, 1'b0, 32'h0);
         chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
         chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
         chk($sformatf("vec%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].valid});
         if (vecs[i].valid) chk($sformatf("vec%0d_pc", i), id_pc, vecs[i].pc);
         advance();
      end

      // redirect in WAIT, word arrives two cycles after grant -> dropped
      rv_delay = 2;
      drive(1'b0, 1'b0, 32'h0);
      chk("pre_redir_addr", imem_addr, 32'h0000_000C);
      advance();
      drive(1'b0, 1'b1, 32'h0000_0103);
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      advance();
      rv_delay = 1;
      drive(1'b0, 1'b0, 32'h0);
      chk("drop_req", {31'd0, imem_req}, 32'd0);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("after_drop_req", {31'd0, imem_req}, 32'd1);
      chk("after_drop_addr", imem_addr, 32'h0000_0100);
      chk("after_drop_valid", {31'd0, id_valid}, 32'd0);
      advance();

      // redirect coincident with rvalid
      drive(1'b0, 1'b1, 32'h0000_0200);
      chk("coinc_rvalid", {31'd0, imem_rvalid}, 32'd1);
      advance();
      drive(1'b0, 1'b1, 32'h0000_0300);
      chk("coinc_req", {31'd0, imem_req}, 32'd1);
      chk("coinc_addr", imem_addr, 32'h0000_0200);
      chk("coinc_valid", {31'd0, id_valid}, 32'd0);
      advance();
      step(1'b0, 1'b0, 32'h0);
      rv_delay = 3;
      drive(1'b0, 1'b0, 32'h0);
      chk("gnt_redir_req", {31'd0, imem_req}, 32'd1);
      chk("gnt_redir_addr", imem_addr, 32'h0000_0300);
      advance();

      // asynchronous reset while waiting for a word
      drive(1'b0, 1'b0, 32'h0);
      chk("pre_rst_req", {31'd0, imem_req}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_addr", imem_addr, 32'h0);
      chk("async_id_pc", id_pc, 32'h0);
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_instr", id_instr, NOP);
      chk("async_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
      model_reset();
      rv_delay = 1;
      @(negedge clk);
      rst_n = 1'b1;

      // restart, and the wrap instance crosses 0xFFFF_FFFC -> 0
      step(1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("wrap_req", {31'd0, imem_req2}, 32'd1);
      chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      advance();
      step(1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      chk("wrap_addr1", imem_addr2, 32'h0);
      chk("wrap_valid", {31'd0, id_valid2}, 32'd1);
      chk("wrap_id_pc", id_pc2, 32'hFFFF_FFFC);
      chk("wrap_instr", id_instr2, KEY);
      advance();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
